// File: rtl/multi_cycle_control_if.sv
// Purpose : control-unit bundle between the multi-cycle controller and its datapath.
// Latency : n/a (signal bundle only).
// Backpressure : memory stalls are signalled by MemReady low; there is no other flow control.
// master = controller (drives strobes/mux selects), slave = datapath/memory side
// (drives IR fields, ALU compare result, interrupt and memory-ready status).
interface multi_cycle_control_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       IRQ;
  logic       KernelMode;
  logic       MemReady;
  logic       BranchCond;
  logic       PCWrite;
  logic       IRWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       ALUSrc1;
  logic       ALUSrc2;
  logic [2:0] PCSrc;
  logic [5:0] ALUFun;
  logic       Sign;
  logic       ExtOp;
  logic       LuOp;
  logic [2:0] State;

  modport master (
    input  OpCode, Funct, IRQ, KernelMode, MemReady, BranchCond,
    output PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemtoReg,
           ALUSrc1, ALUSrc2, PCSrc, ALUFun, Sign, ExtOp, LuOp, State
  );

  modport slave (
    output OpCode, Funct, IRQ, KernelMode, MemReady, BranchCond,
    input  PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemtoReg,
           ALUSrc1, ALUSrc2, PCSrc, ALUFun, Sign, ExtOp, LuOp, State
  );
endinterface

// File: rtl/multi_cycle_control.sv
// Purpose : FETCH/DECODE/EXEC/MEM/WB sequencer with IRQ, undefined-op and bus-timeout traps.
// Latency : R 4, lw 5, sw 4, branch 3, jumps 2 cycles (+1 for a trap) with MemReady immediate.
// Backpressure : FETCH and MEM hold while MemReady=0; a stall of MEM_TIMEOUT cycles traps.
// Ports: clk, reset (async active-low); bus (master) carries IR fields, IRQ, KernelMode,
// MemReady, BranchCond in and all PC/IR/memory/register-file/ALU controls plus State out.
module multi_cycle_control #(
  parameter int IRQ_SYNC    = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int XADR_EN     = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  multi_cycle_control_if.master       bus
);

  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2,
                            MEM = 3'd3, WB = 3'd4, TRAP = 3'd5} state_t;
  typedef enum logic [1:0] {CAUSE_IRQ = 2'd0, CAUSE_XADR = 2'd1, CAUSE_BUS = 2'd2} cause_t;

  localparam logic [5:0] ALU_ADD = 6'b000000, ALU_SUB = 6'b000001, ALU_AND = 6'b011000,
                         ALU_OR  = 6'b011110, ALU_XOR = 6'b010110, ALU_NOR = 6'b010001,
                         ALU_SLL = 6'b100000, ALU_SRL = 6'b100001, ALU_SRA = 6'b100011,
                         ALU_EQ  = 6'b110011, ALU_NEQ = 6'b110001, ALU_LT  = 6'b110101,
                         ALU_LEZ = 6'b111101, ALU_LTZ = 6'b111011, ALU_GTZ = 6'b111111;
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);
  localparam bit XADR_ON = (XADR_EN != 0);
  localparam bit TMO_ON  = (MEM_TIMEOUT > 0);

  state_t         state_q, state_d;
  cause_t         cause_q, cause_d;
  logic           pend_q, pend_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           irq_s;

  // IRQ is asynchronous; IRQ_SYNC=0 means the source is already in this clock domain.
  if (IRQ_SYNC == 0) begin : g_irq_raw
    assign irq_s = bus.IRQ;
  end else begin : g_irq_sync
    logic [IRQ_SYNC-1:0] sync_q, sync_d;
    always_comb sync_d = IRQ_SYNC'({sync_q, bus.IRQ});
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= sync_d;
    end
    assign irq_s = sync_q[IRQ_SYNC-1];
  end

  // Instruction decode (identical to the single-cycle unit's ALU side).
  logic [5:0] alu_fun;
  logic alu_src1, alu_src2, sign, ext_op, lu_op, undef;
  logic is_r, is_lw, is_sw, is_j, is_jal, is_jr, is_jalr, is_branch;

  always_comb begin
    alu_fun  = ALU_ADD;
    alu_src1 = 1'b0;
    alu_src2 = 1'b0;
    sign     = 1'b1;
    ext_op   = 1'b1;
    lu_op    = 1'b0;
    undef    = 1'b0;
    is_r      = (bus.OpCode == 6'h00);
    is_lw     = (bus.OpCode == 6'h23);
    is_sw     = (bus.OpCode == 6'h2b);
    is_j      = (bus.OpCode == 6'h02);
    is_jal    = (bus.OpCode == 6'h03);
    is_jr     = is_r && (bus.Funct == 6'h08);
    is_jalr   = is_r && (bus.Funct == 6'h09);
    is_branch = (bus.OpCode == 6'h01) || (bus.OpCode >= 6'h04 && bus.OpCode <= 6'h07);
    case (bus.OpCode)
      6'h00: begin
        case (bus.Funct)
          6'h20, 6'h08, 6'h09: begin end
          6'h21: sign = 1'b0;
          6'h22: alu_fun = ALU_SUB;
          6'h23: begin alu_fun = ALU_SUB; sign = 1'b0; end
          6'h24: alu_fun = ALU_AND;
          6'h25: alu_fun = ALU_OR;
          6'h26: alu_fun = ALU_XOR;
          6'h27: alu_fun = ALU_NOR;
          6'h00: begin alu_fun = ALU_SLL; alu_src1 = 1'b1; end
          6'h02: begin alu_fun = ALU_SRL; alu_src1 = 1'b1; end
          6'h03: begin alu_fun = ALU_SRA; alu_src1 = 1'b1; end
          6'h2a: alu_fun = ALU_LT;
          6'h2b: begin alu_fun = ALU_LT; sign = 1'b0; end
          default: undef = 1'b1;
        endcase
      end
      6'h23, 6'h2b, 6'h08: alu_src2 = 1'b1;
      6'h09: begin alu_src2 = 1'b1; sign = 1'b0; end
      6'h0f: begin alu_src2 = 1'b1; lu_op = 1'b1; end
      6'h0c: begin alu_fun = ALU_AND; alu_src2 = 1'b1; ext_op = 1'b0; end
      6'h0a: begin alu_fun = ALU_LT; alu_src2 = 1'b1; end
      6'h0b: begin alu_fun = ALU_LT; alu_src2 = 1'b1; sign = 1'b0; end
      6'h04: alu_fun = ALU_EQ;
      6'h05: alu_fun = ALU_NEQ;
      6'h06: alu_fun = ALU_LEZ;
      6'h07: alu_fun = ALU_GTZ;
      6'h01: alu_fun = ALU_LTZ;
      6'h02, 6'h03: begin end
      default: undef = 1'b1;
    endcase
  end

  // Sequencer: next state plus all state-dependent strobes.
  logic pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg;
  logic [2:0] pc_src;
  logic tmo_hit;

  // Timeout fires on the last allowed stall cycle only if MemReady is still low.
  assign tmo_hit = TMO_ON && (cnt_q == TMO_LAST) && !bus.MemReady;

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    pend_d     = pend_q | irq_s;
    cnt_d      = '0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    pc_src     = 3'b000;
    case (state_q)
      FETCH: begin
        mem_read = 1'b1;
        if (bus.MemReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (tmo_hit) begin
          state_d = TRAP;
          cause_d = CAUSE_BUS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DECODE: begin
        if (undef && XADR_ON && !bus.KernelMode) begin
          state_d = TRAP;
          cause_d = CAUSE_XADR;
        end else if (pend_q && !bus.KernelMode) begin
          state_d = TRAP;
          cause_d = CAUSE_IRQ;
          pend_d  = irq_s;  // drop the taken request; a still-high IRQ re-arms it
        end else if (is_j || is_jal) begin
          pc_write = 1'b1;
          pc_src   = 3'b010;
          if (is_jal) begin
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
          state_d = FETCH;
        end else if (is_jr || is_jalr) begin
          pc_write = 1'b1;
          pc_src   = 3'b011;
          if (is_jalr) begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b10;
          end
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_branch) begin
          pc_write = bus.BranchCond;
          pc_src   = 3'b001;
          state_d  = FETCH;
        end else if (is_lw || is_sw) begin
          state_d = MEM;
        end else if (undef) begin
          state_d = FETCH;  // untrapped undefined op retires as a NOP, no write-back
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        iord      = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
        if (bus.MemReady) begin
          state_d = is_lw ? WB : FETCH;
        end else if (tmo_hit) begin
          state_d = TRAP;
          cause_d = CAUSE_BUS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_r ? 2'b00 : 2'b01;
        mem_to_reg = is_lw ? 2'b01 : 2'b00;
        state_d    = FETCH;
      end
      TRAP: begin
        reg_write = 1'b1;
        reg_dst   = 2'b11;
        pc_write  = 1'b1;
        case (cause_q)
          CAUSE_IRQ:  begin mem_to_reg = 2'b11; pc_src = 3'b100; end
          CAUSE_XADR: begin mem_to_reg = 2'b10; pc_src = 3'b101; end
          default:    begin mem_to_reg = 2'b11; pc_src = 3'b110; end
        endcase
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      cause_q <= CAUSE_IRQ;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write strobes are gated by reset so nothing reaches PC/IR/memory/regfile while it is held.
  assign bus.PCWrite  = pc_write  & reset;
  assign bus.IRWrite  = ir_write  & reset;
  assign bus.MemRead  = mem_read  & reset;
  assign bus.MemWrite = mem_write & reset;
  assign bus.RegWrite = reg_write & reset;
  assign bus.IorD     = iord;
  assign bus.RegDst   = reg_dst;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.PCSrc    = pc_src;
  assign bus.ALUFun   = alu_fun;
  assign bus.ALUSrc1  = alu_src1;
  assign bus.ALUSrc2  = alu_src2;
  assign bus.Sign     = sign;
  assign bus.ExtOp    = ext_op;
  assign bus.LuOp     = lu_op;
  assign bus.State    = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
module tb_multi_cycle_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] op = 6'h00;
  logic [5:0] fn = 6'h20;
  logic irq = 1'b0;
  logic km = 1'b0;
  logic mrdy = 1'b0;
  logic bc = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  multi_cycle_control_if bus ();
  multi_cycle_control_if bus_nx ();

  assign bus.OpCode = op;      assign bus_nx.OpCode = op;
  assign bus.Funct = fn;       assign bus_nx.Funct = fn;
  assign bus.IRQ = irq;        assign bus_nx.IRQ = irq;
  assign bus.KernelMode = km;  assign bus_nx.KernelMode = km;
  assign bus.MemReady = mrdy;  assign bus_nx.MemReady = mrdy;
  assign bus.BranchCond = bc;  assign bus_nx.BranchCond = bc;

  multi_cycle_control u_dut (.clk(clk), .reset(rst_n), .bus(bus));
  multi_cycle_control #(.XADR_EN(0)) u_nx (.clk(clk), .reset(rst_n), .bus(bus_nx));

  // {State, PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemtoReg, PCSrc}
  logic [15:0] obs, obs_nx;
  assign obs = {bus.State, bus.PCWrite, bus.IRWrite, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.PCSrc};
  assign obs_nx = {bus_nx.State, bus_nx.PCWrite, bus_nx.IRWrite, bus_nx.IorD, bus_nx.MemRead,
                   bus_nx.MemWrite, bus_nx.RegWrite, bus_nx.RegDst, bus_nx.MemtoReg, bus_nx.PCSrc};
  // {ALUFun, ALUSrc1, ALUSrc2, Sign, ExtOp, LuOp}
  logic [10:0] alu_obs, alu_obs_nx;
  assign alu_obs = {bus.ALUFun, bus.ALUSrc1, bus.ALUSrc2, bus.Sign, bus.ExtOp, bus.LuOp};
  assign alu_obs_nx = {bus_nx.ALUFun, bus_nx.ALUSrc1, bus_nx.ALUSrc2, bus_nx.Sign,
                       bus_nx.ExtOp, bus_nx.LuOp};

  function automatic logic [15:0] ev(input logic [2:0] st, input logic [5:0] strb,
                                     input logic [1:0] dst, input logic [1:0] m2r,
                                     input logic [2:0] src);
    return {st, strb, dst, m2r, src};
  endfunction

  logic [15:0] F_OK, F_WAIT, DEC_V, EXE_V, WB_R, WB_I, WB_LD, MEM_LD, MEM_ST, BR_T, BR_NT;
  logic [15:0] TRAP_IRQ, TRAP_X, TRAP_BUS, JAL_V, JALR_V, J_V, JR_V;

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if (obs !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_hold: got %b, expected %b", obs, 16'h0000);
    end
    tests_run++;
    if (obs_nx !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_hold_nx: got %b, expected %b", obs_nx, 16'h0000);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (obs !== F_WAIT) begin
      tests_failed++;
      $display("FAIL reset_release: got %b, expected %b", obs, F_WAIT);
    end
  endtask

  task automatic test_add();
    logic [15:0] ex [4] = '{F_OK, DEC_V, EXE_V, WB_R};
    op = 6'h00; fn = 6'h20; mrdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== ex[i]) begin
        tests_failed++;
        $display("FAIL add cycle %0d: got %b, expected %b", i, obs, ex[i]);
      end
      if (i == 2) begin
        tests_run++;
        if (alu_obs !== 11'b000000_00110) begin
          tests_failed++;
          $display("FAIL add_alu: got %b, expected %b", alu_obs, 11'b000000_00110);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    logic [15:0] ex [8] = '{F_OK, DEC_V, EXE_V, MEM_LD, MEM_LD, MEM_LD, MEM_LD, WB_LD};
    logic mr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    op = 6'h23; fn = 6'h00;
    for (int i = 0; i < 8; i++) begin
      mrdy = mr[i];
      @(negedge clk);
      tests_run++;
      if (obs !== ex[i]) begin
        tests_failed++;
        $display("FAIL lw cycle %0d: got %b, expected %b", i, obs, ex[i]);
      end
      if (i == 2) begin
        tests_run++;
        if (alu_obs !== 11'b000000_01110) begin
          tests_failed++;
          $display("FAIL lw_alu: got %b, expected %b", alu_obs, 11'b000000_01110);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [15:0] ex [6] = '{F_OK, DEC_V, BR_T, F_OK, DEC_V, BR_NT};
    logic bcv [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    op = 6'h04; fn = 6'h00; mrdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bc = bcv[i];
      @(negedge clk);
      tests_run++;
      if (obs !== ex[i]) begin
        tests_failed++;
        $display("FAIL beq cycle %0d: got %b, expected %b", i, obs, ex[i]);
      end
      if (i == 2) begin
        tests_run++;
        if (alu_obs !== 11'b110011_00110) begin
          tests_failed++;
          $display("FAIL beq_alu: got %b, expected %b", alu_obs, 11'b110011_00110);
        end
      end
      @(posedge clk); #1;
    end
    bc = 1'b0;
  endtask

  task automatic test_irq();
    logic [15:0] ex1 [10] = '{F_WAIT, F_WAIT, F_WAIT, F_OK, DEC_V, TRAP_IRQ, F_OK, DEC_V, EXE_V, WB_R};
    logic mr1 [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] ex2 [7] = '{F_WAIT, F_WAIT, F_WAIT, F_OK, DEC_V, EXE_V, WB_R};
    logic [15:0] ex3 [3] = '{F_OK, DEC_V, TRAP_IRQ};
    op = 6'h00; fn = 6'h20;
    // KernelMode=0: a one-cycle pulse becomes pending and traps the next DECODE, then clears.
    km = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mrdy = mr1[i];
      irq = (i == 0);
      @(negedge clk);
      tests_run++;
      if (obs !== ex1[i]) begin
        tests_failed++;
        $display("FAIL irq_user cycle %0d: got %b, expected %b", i, obs, ex1[i]);
      end
      @(posedge clk); #1;
    end
    // KernelMode=1: the instruction executes normally and the request stays pending.
    km = 1'b1;
    for (int i = 0; i < 7; i++) begin
      mrdy = mr1[i];
      irq = (i == 0);
      @(negedge clk);
      tests_run++;
      if (obs !== ex2[i]) begin
        tests_failed++;
        $display("FAIL irq_kernel cycle %0d: got %b, expected %b", i, obs, ex2[i]);
      end
      @(posedge clk); #1;
    end
    // Back in user mode, the held request traps without a new pulse.
    km = 1'b0;
    irq = 1'b0;
    mrdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== ex3[i]) begin
        tests_failed++;
        $display("FAIL irq_held cycle %0d: got %b, expected %b", i, obs, ex3[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_xadr();
    logic [15:0] ex [3] = '{F_OK, DEC_V, TRAP_X};
    logic [15:0] exn [3] = '{F_OK, DEC_V, EXE_V};
    op = 6'h3f; fn = 6'h00; mrdy = 1'b1; km = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== ex[i]) begin
        tests_failed++;
        $display("FAIL xadr cycle %0d: got %b, expected %b", i, obs, ex[i]);
      end
      tests_run++;
      if (obs_nx !== exn[i]) begin
        tests_failed++;
        $display("FAIL xadr_nop cycle %0d: got %b, expected %b", i, obs_nx, exn[i]);
      end
      if (i == 2) begin
        tests_run++;
        if (alu_obs_nx !== 11'b000000_00110) begin
          tests_failed++;
          $display("FAIL xadr_nop_alu: got %b, expected %b", alu_obs_nx, 11'b000000_00110);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    logic [15:0] tail [4] = '{F_OK, DEC_V, EXE_V, WB_R};
    logic [15:0] exp_v;
    op = 6'h00; fn = 6'h20;
    // 16 stalled FETCH cycles, then the bus-error trap.
    for (int i = 0; i < 17; i++) begin
      mrdy = 1'b0;
      exp_v = (i < 16) ? F_WAIT : TRAP_BUS;
      @(negedge clk);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL timeout cycle %0d: got %b, expected %b", i, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    // MemReady on the final allowed cycle completes the fetch instead of trapping.
    for (int i = 0; i < 19; i++) begin
      mrdy = (i >= 15);
      exp_v = (i < 15) ? F_WAIT : tail[i - 15];
      @(negedge clk);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL timeout_race cycle %0d: got %b, expected %b", i, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [16] = '{6'h03, 6'h03, 6'h00, 6'h00, 6'h02, 6'h02, 6'h00, 6'h00,
                             6'h2b, 6'h2b, 6'h2b, 6'h2b, 6'h08, 6'h08, 6'h08, 6'h08};
    logic [5:0] fns [16] = '{6'h00, 6'h00, 6'h09, 6'h09, 6'h00, 6'h00, 6'h08, 6'h08,
                             6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    logic [15:0] ex [16] = '{F_OK, JAL_V, F_OK, JALR_V, F_OK, J_V, F_OK, JR_V,
                             F_OK, DEC_V, EXE_V, MEM_ST, F_OK, DEC_V, EXE_V, WB_I};
    mrdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      op = ops[i];
      fn = fns[i];
      @(negedge clk);
      tests_run++;
      if (obs !== ex[i]) begin
        tests_failed++;
        $display("FAIL b2b cycle %0d: got %b, expected %b", i, obs, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [15:0] ex [4] = '{F_OK, DEC_V, EXE_V, MEM_LD};
    op = 6'h23; fn = 6'h00;
    for (int i = 0; i < 4; i++) begin
      mrdy = (i < 3);
      @(negedge clk);
      tests_run++;
      if (obs !== ex[i]) begin
        tests_failed++;
        $display("FAIL rst_mem cycle %0d: got %b, expected %b", i, obs, ex[i]);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (obs !== 16'h0000) begin
      tests_failed++;
      $display("FAIL rst_mem_assert: got %b, expected %b", obs, 16'h0000);
    end
    tests_run++;
    if (obs_nx !== 16'h0000) begin
      tests_failed++;
      $display("FAIL rst_mem_assert_nx: got %b, expected %b", obs_nx, 16'h0000);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (obs !== F_WAIT) begin
      tests_failed++;
      $display("FAIL rst_mem_release: got %b, expected %b", obs, F_WAIT);
    end
  endtask

  initial begin
    F_OK     = ev(3'd0, 6'b110100, 2'b00, 2'b00, 3'b000);
    F_WAIT   = ev(3'd0, 6'b000100, 2'b00, 2'b00, 3'b000);
    DEC_V    = ev(3'd1, 6'b000000, 2'b00, 2'b00, 3'b000);
    EXE_V    = ev(3'd2, 6'b000000, 2'b00, 2'b00, 3'b000);
    WB_R     = ev(3'd4, 6'b000001, 2'b00, 2'b00, 3'b000);
    WB_I     = ev(3'd4, 6'b000001, 2'b01, 2'b00, 3'b000);
    WB_LD    = ev(3'd4, 6'b000001, 2'b01, 2'b01, 3'b000);
    MEM_LD   = ev(3'd3, 6'b001100, 2'b00, 2'b00, 3'b000);
    MEM_ST   = ev(3'd3, 6'b001010, 2'b00, 2'b00, 3'b000);
    BR_T     = ev(3'd2, 6'b100000, 2'b00, 2'b00, 3'b001);
    BR_NT    = ev(3'd2, 6'b000000, 2'b00, 2'b00, 3'b001);
    TRAP_IRQ = ev(3'd5, 6'b100001, 2'b11, 2'b11, 3'b100);
    TRAP_X   = ev(3'd5, 6'b100001, 2'b11, 2'b10, 3'b101);
    TRAP_BUS = ev(3'd5, 6'b100001, 2'b11, 2'b11, 3'b110);
    JAL_V    = ev(3'd1, 6'b100001, 2'b10, 2'b10, 3'b010);
    JALR_V   = ev(3'd1, 6'b100001, 2'b00, 2'b10, 3'b011);
    J_V      = ev(3'd1, 6'b100000, 2'b00, 2'b00, 3'b010);
    JR_V     = ev(3'd1, 6'b100000, 2'b00, 2'b00, 3'b011);

    test_reset();
    test_add();
    test_lw();
    test_branch();
    test_irq();
    test_xadr();
    test_timeout();
    test_back_to_back();
    test_reset_mid_mem();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
